// File: rtl/wb_retire_unit_if.sv
// Signal bundle between the write-back/retire stage and its neighbours.
//   MEM side   : i_valid/o_ready handshake, i_flush and the MEM/WB payload fields.
//   Regfile    : o_wb_rd, o_wb_data, o_wb_we.
//   Trace port : o_tr_valid/i_tr_ready show-ahead drain plus the head record fields.
//   Status     : o_halted (sticky), o_instret.
// The master modport drives the stage (pipeline + trace consumer).
// The slave modport is the stage itself.
interface wb_retire_unit_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 64
);
  logic             i_valid;
  logic             o_ready;
  logic             i_flush;
  logic [31:0]      i_inst;
  logic [XLEN-1:0]  i_pc;
  logic [XLEN-1:0]  i_next_pc;
  logic [4:0]       i_rd;
  logic             i_reg_write;
  logic             i_mem_to_reg;
  logic [XLEN-1:0]  i_load_data;
  logic [XLEN-1:0]  i_alu_result;
  logic [XLEN-1:0]  i_imm;
  logic             i_unaligned_pc;
  logic             i_unaligned_mem;
  logic [4:0]       o_wb_rd;
  logic [XLEN-1:0]  o_wb_data;
  logic             o_wb_we;
  logic             o_tr_valid;
  logic             i_tr_ready;
  logic [XLEN-1:0]  o_tr_pc;
  logic [XLEN-1:0]  o_tr_next_pc;
  logic [31:0]      o_tr_inst;
  logic [4:0]       o_tr_rd;
  logic [XLEN-1:0]  o_tr_rd_wdata;
  logic             o_tr_trap;
  logic             o_tr_halt;
  logic             o_halted;
  logic [CNT_W-1:0] o_instret;

  modport master (
    output i_valid, i_flush, i_inst, i_pc, i_next_pc, i_rd, i_reg_write, i_mem_to_reg,
           i_load_data, i_alu_result, i_imm, i_unaligned_pc, i_unaligned_mem, i_tr_ready,
    input  o_ready, o_wb_rd, o_wb_data, o_wb_we, o_tr_valid, o_tr_pc, o_tr_next_pc,
           o_tr_inst, o_tr_rd, o_tr_rd_wdata, o_tr_trap, o_tr_halt, o_halted, o_instret
  );

  modport slave (
    input  i_valid, i_flush, i_inst, i_pc, i_next_pc, i_rd, i_reg_write, i_mem_to_reg,
           i_load_data, i_alu_result, i_imm, i_unaligned_pc, i_unaligned_mem, i_tr_ready,
    output o_ready, o_wb_rd, o_wb_data, o_wb_we, o_tr_valid, o_tr_pc, o_tr_next_pc,
           o_tr_inst, o_tr_rd, o_tr_rd_wdata, o_tr_trap, o_tr_halt, o_halted, o_instret
  );
endinterface

// File: rtl/wb_retire_unit.sv
// RV32I write-back/retire stage.
// Holds the MEM/WB register (stall + flush), selects regfile write data, detects
// traps/halts, pushes one retire record per instruction into a show-ahead trace FIFO
// and counts retired instructions. A full FIFO back-pressures MEM instead of dropping.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : wb_retire_unit_if slave (MEM handshake, regfile write, trace drain,
//                  o_halted, o_instret)
module wb_retire_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 64
) (
  input logic            i_clk,
  input logic            i_rst,
  wb_retire_unit_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // MEM/WB pipeline register
  logic            wb_valid;
  logic [31:0]     wb_inst;
  logic [XLEN-1:0] wb_pc, wb_next_pc, wb_load_data, wb_alu_result, wb_imm;
  logic [4:0]      wb_rd;
  logic            wb_reg_write, wb_mem_to_reg, wb_unaligned_pc, wb_unaligned_mem;

  // Trace FIFO
  logic [XLEN-1:0] f_pc      [DEPTH];
  logic [XLEN-1:0] f_next_pc [DEPTH];
  logic [31:0]     f_inst    [DEPTH];
  logic [4:0]      f_rd      [DEPTH];
  logic [XLEN-1:0] f_wdata   [DEPTH];
  logic            f_trap    [DEPTH];
  logic            f_halt    [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   count;

  logic             halted;
  logic [CNT_W-1:0] instret;

  logic [6:0]      opcode;
  logic [XLEN-1:0] wb_data;
  logic            legal, trap, halt, fifo_full, fire, pop, ready, wb_we, tr_valid;

  assign opcode    = wb_inst[6:0];
  assign fifo_full = (count == (PTR_W+1)'(DEPTH));
  assign fire      = wb_valid && !fifo_full && !halted;
  assign ready     = !halted && (!wb_valid || fire);
  assign tr_valid  = (count != '0);
  assign pop       = tr_valid && bus.i_tr_ready;

  always_comb begin
    wb_data = wb_alu_result;
    if (wb_mem_to_reg)                             wb_data = wb_load_data;
    else if (opcode == OP_JAL || opcode == OP_JALR) wb_data = wb_pc + XLEN'(4);
    else if (opcode == OP_LUI)                      wb_data = wb_imm;
    else if (opcode == OP_AUIPC)                    wb_data = wb_pc + wb_imm;
  end

  assign legal = opcode inside {OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL,
                                OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM};
  assign trap  = wb_valid && (!legal || wb_unaligned_pc || wb_unaligned_mem);
  // EBREAK: SYSTEM, funct3 000, imm 001
  assign halt  = trap || (wb_valid && opcode == OP_SYSTEM && wb_inst[14:12] == 3'b000 &&
                          wb_inst[31:20] == 12'h001);
  assign wb_we = fire && wb_reg_write && (wb_rd != 5'd0) && !trap;

  assign bus.o_ready   = ready;
  assign bus.o_wb_we   = wb_we;
  assign bus.o_wb_rd   = wb_rd;
  assign bus.o_wb_data = wb_data;
  assign bus.o_halted  = halted;
  assign bus.o_instret = instret;

  // Head fields are gated so stale storage never shows after reset.
  assign bus.o_tr_valid    = tr_valid;
  assign bus.o_tr_pc       = tr_valid ? f_pc[rd_ptr]      : '0;
  assign bus.o_tr_next_pc  = tr_valid ? f_next_pc[rd_ptr] : '0;
  assign bus.o_tr_inst     = tr_valid ? f_inst[rd_ptr]    : '0;
  assign bus.o_tr_rd       = tr_valid ? f_rd[rd_ptr]      : '0;
  assign bus.o_tr_rd_wdata = tr_valid ? f_wdata[rd_ptr]   : '0;
  assign bus.o_tr_trap     = tr_valid && f_trap[rd_ptr];
  assign bus.o_tr_halt     = tr_valid && f_halt[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wb_valid         <= 1'b0;
      wb_inst          <= '0;
      wb_pc            <= '0;
      wb_next_pc       <= '0;
      wb_rd            <= '0;
      wb_reg_write     <= 1'b0;
      wb_mem_to_reg    <= 1'b0;
      wb_load_data     <= '0;
      wb_alu_result    <= '0;
      wb_imm           <= '0;
      wb_unaligned_pc  <= 1'b0;
      wb_unaligned_mem <= 1'b0;
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      count            <= '0;
      halted           <= 1'b0;
      instret          <= '0;
    end else begin
      if (ready) begin
        wb_valid         <= bus.i_valid && !bus.i_flush;
        wb_inst          <= bus.i_inst;
        wb_pc            <= bus.i_pc;
        wb_next_pc       <= bus.i_next_pc;
        wb_rd            <= bus.i_rd;
        wb_reg_write     <= bus.i_reg_write;
        wb_mem_to_reg    <= bus.i_mem_to_reg;
        wb_load_data     <= bus.i_load_data;
        wb_alu_result    <= bus.i_alu_result;
        wb_imm           <= bus.i_imm;
        wb_unaligned_pc  <= bus.i_unaligned_pc;
        wb_unaligned_mem <= bus.i_unaligned_mem;
      end
      if (fire) begin
        wr_ptr  <= wr_ptr + PTR_W'(1);
        instret <= instret + CNT_W'(1);
        if (halt) halted <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (fire && !pop)      count <= count + (PTR_W+1)'(1);
      else if (!fire && pop) count <= count - (PTR_W+1)'(1);
    end
  end

  // Storage needs no reset: reads are gated by count.
  always_ff @(posedge i_clk) begin
    if (fire) begin
      f_pc[wr_ptr]      <= wb_pc;
      f_next_pc[wr_ptr] <= wb_next_pc;
      f_inst[wr_ptr]    <= wb_inst;
      f_rd[wr_ptr]      <= wb_we ? wb_rd : 5'd0;
      f_wdata[wr_ptr]   <= wb_we ? wb_data : '0;
      f_trap[wr_ptr]    <= trap;
      f_halt[wr_ptr]    <= halt;
    end
  end
endmodule

// File: tb/tb_wb_retire_unit.sv
module tb_wb_retire_unit;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 64;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  wb_retire_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  wb_retire_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        v;
    logic [31:0] inst, pc, next_pc, load_data, alu, imm;
    logic [4:0]  rd;
    logic        reg_write, mem_to_reg, upc, umem;
  } instr_t;

  typedef struct {
    logic [31:0] pc, next_pc, inst, wdata;
    logic [4:0]  rd;
    logic        trap, halt;
  } rec_t;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: architectural rules of RV32I retirement.
  function automatic logic [31:0] ref_wdata(input instr_t t);
    if (t.mem_to_reg) return t.load_data;
    case (t.inst[6:0])
      7'b1101111, 7'b1100111: return t.pc + 32'd4;
      7'b0110111:             return t.imm;
      7'b0010111:             return t.pc + t.imm;
      default:                return t.alu;
    endcase
  endfunction

  function automatic logic ref_trap(input instr_t t);
    logic [6:0] op;
    op = t.inst[6:0];
    if (!t.v) return 1'b0;
    return !(op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                        7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011})
           || t.upc || t.umem;
  endfunction

  function automatic logic ref_halt(input instr_t t);
    return ref_trap(t) || (t.v && t.inst[6:0] == 7'b1110011 && t.inst[14:12] == 3'b000 &&
                           t.inst[31:20] == 12'h001);
  endfunction

  task automatic drive(input instr_t t, input logic valid, input logic flush);
    bus.i_valid         = valid;
    bus.i_flush         = flush;
    bus.i_inst          = t.inst;
    bus.i_pc            = t.pc;
    bus.i_next_pc       = t.next_pc;
    bus.i_rd            = t.rd;
    bus.i_reg_write     = t.reg_write;
    bus.i_mem_to_reg    = t.mem_to_reg;
    bus.i_load_data     = t.load_data;
    bus.i_alu_result    = t.alu;
    bus.i_imm           = t.imm;
    bus.i_unaligned_pc  = t.upc;
    bus.i_unaligned_mem = t.umem;
  endtask

  task automatic check_reset_state(input string pfx);
    check_eq({pfx, "_ready"},    64'(bus.o_ready), 64'd1);
    check_eq({pfx, "_tr_valid"}, 64'(bus.o_tr_valid), 64'd0);
    check_eq({pfx, "_tr_pc"},    64'(bus.o_tr_pc), 64'd0);
    check_eq({pfx, "_tr_rd"},    64'(bus.o_tr_rd), 64'd0);
    check_eq({pfx, "_instret"},  bus.o_instret, 64'd0);
    check_eq({pfx, "_halted"},   64'(bus.o_halted), 64'd0);
    check_eq({pfx, "_wb_we"},    64'(bus.o_wb_we), 64'd0);
    check_eq({pfx, "_wb_rd"},    64'(bus.o_wb_rd), 64'd0);
    check_eq({pfx, "_wb_data"},  64'(bus.o_wb_data), 64'd0);
  endtask

  function automatic instr_t rand_instr();
    instr_t t;
    logic [6:0] ops [10];
    int unsigned sel;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011};
    sel = $urandom_range(0, 99);
    t.inst = $urandom;
    if (sel < 94)       t.inst[6:0] = ops[$urandom_range(0, 9)];
    else if (sel < 96)  t.inst[6:0] = 7'h7F;
    else if (sel < 97)  t.inst = 32'h0010_0073;  // EBREAK
    t.v          = 1'b0;
    t.pc         = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    t.next_pc    = $urandom;
    t.rd         = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    t.reg_write  = $urandom_range(0, 3) != 0;
    t.mem_to_reg = $urandom_range(0, 4) == 0;
    t.load_data  = $urandom;
    t.alu        = $urandom;
    t.imm        = $urandom;
    t.upc        = $urandom_range(0, 99) == 0;
    t.umem       = $urandom_range(0, 99) == 0;
    return t;
  endfunction

  instr_t      m_wb;
  rec_t        m_q[$];
  logic        m_halted;
  longint unsigned m_instret;

  initial begin
    instr_t t, cur;
    rec_t   r;
    logic   e_fire, e_ready, e_we, e_pop, e_trap, e_halt;
    logic [31:0] e_data;
    int unsigned rdy_pct;

    t = rand_instr();
    t.reg_write = 1'b0; t.mem_to_reg = 1'b0; t.upc = 1'b0; t.umem = 1'b0;
    drive(t, 1'b0, 1'b0);
    bus.i_tr_ready = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1 check_reset_state("rst0");

    // ADDI x5, x0, 10 with the consumer always ready
    t.inst = 32'h00A0_0293; t.pc = 32'h0; t.next_pc = 32'h4; t.rd = 5'd5;
    t.reg_write = 1'b1; t.alu = 32'd10;
    drive(t, 1'b1, 1'b0);
    @(negedge i_clk);
    bus.i_valid = 1'b0;
    #1;
    check_eq("addi_we",   64'(bus.o_wb_we), 64'd1);
    check_eq("addi_rd",   64'(bus.o_wb_rd), 64'd5);
    check_eq("addi_data", 64'(bus.o_wb_data), 64'd10);
    @(negedge i_clk);
    #1;
    check_eq("addi_tr_valid", 64'(bus.o_tr_valid), 64'd1);
    check_eq("addi_tr_rd",    64'(bus.o_tr_rd), 64'd5);
    check_eq("addi_tr_wdata", 64'(bus.o_tr_rd_wdata), 64'd10);
    check_eq("addi_instret",  bus.o_instret, 64'd1);

    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    #1 check_reset_state("rst1");

    m_wb.v = 1'b0; m_q.delete(); m_halted = 1'b0; m_instret = 0;

    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge i_clk);
      case ((cyc / 500) % 3)
        0:       rdy_pct = 90;
        1:       rdy_pct = 15;
        default: rdy_pct = 50;
      endcase
      i_rst = ($urandom_range(0, 149) == 0);
      bus.i_tr_ready = $urandom_range(0, 99) < rdy_pct;
      cur = rand_instr();
      cur.v = ($urandom_range(0, 99) < 75);
      drive(cur, cur.v, $urandom_range(0, 9) == 0);
      cur.v = bus.i_valid && !bus.i_flush;
      #1;

      e_trap  = ref_trap(m_wb);
      e_halt  = ref_halt(m_wb);
      e_data  = ref_wdata(m_wb);
      e_fire  = m_wb.v && (m_q.size() < DEPTH) && !m_halted;
      e_ready = !m_halted && (!m_wb.v || e_fire);
      e_we    = e_fire && m_wb.reg_write && (m_wb.rd != 5'd0) && !e_trap;
      e_pop   = (m_q.size() != 0) && bus.i_tr_ready;

      check_eq("ready",    64'(bus.o_ready), 64'(e_ready));
      check_eq("wb_we",    64'(bus.o_wb_we), 64'(e_we));
      if (m_wb.v) begin
        check_eq("wb_rd",   64'(bus.o_wb_rd), 64'(m_wb.rd));
        check_eq("wb_data", 64'(bus.o_wb_data), 64'(e_data));
      end
      check_eq("halted",   64'(bus.o_halted), 64'(m_halted));
      check_eq("instret",  bus.o_instret, 64'(m_instret));
      check_eq("tr_valid", 64'(bus.o_tr_valid), 64'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        check_eq("tr_pc",      64'(bus.o_tr_pc), 64'(m_q[0].pc));
        check_eq("tr_next_pc", 64'(bus.o_tr_next_pc), 64'(m_q[0].next_pc));
        check_eq("tr_inst",    64'(bus.o_tr_inst), 64'(m_q[0].inst));
        check_eq("tr_rd",      64'(bus.o_tr_rd), 64'(m_q[0].rd));
        check_eq("tr_wdata",   64'(bus.o_tr_rd_wdata), 64'(m_q[0].wdata));
        check_eq("tr_trap",    64'(bus.o_tr_trap), 64'(m_q[0].trap));
        check_eq("tr_halt",    64'(bus.o_tr_halt), 64'(m_q[0].halt));
      end

      @(posedge i_clk);
      if (i_rst) begin
        m_wb.v = 1'b0; m_q.delete(); m_halted = 1'b0; m_instret = 0;
      end else begin
        if (e_pop) void'(m_q.pop_front());
        if (e_fire) begin
          r.pc = m_wb.pc; r.next_pc = m_wb.next_pc; r.inst = m_wb.inst;
          r.rd = e_we ? m_wb.rd : 5'd0; r.wdata = e_we ? e_data : 32'd0;
          r.trap = e_trap; r.halt = e_halt;
          m_q.push_back(r);
          m_instret++;
          if (e_halt) m_halted = 1'b1;
        end
        if (e_ready) m_wb = cur;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
